lsu_mem_ctrl: RTL
=================

# lsu_mem_ctrl

Load/store controller sitting directly upstream of the word-addressed data memory. It accepts byte-addressed load/store requests from the execute stage over a valid/ready handshake, checks alignment and range, and sequences each access onto the memory's single synchronous port (address, data, write-enable, registered read data). It then returns one response per request over a second valid/ready handshake. Only one request is in flight at a time.

## Interface
- DEPTH, 32, number of 32-bit words in the downstream memory; legal word index 0..DEPTH-1
- AW, 32, width of the byte request address
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  reset, synchronous and active-low (single clock domain)
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_write  in  1  1 = store, 0 = load
- req_addr  in  AW  byte address
- req_wdata  in  32  store data
- resp_valid  out  1  response present
- resp_ready  in  1  consumer takes the response
- resp_rdata  out  32  load data; 0 for stores and errors
- resp_err  out  1  request rejected (misaligned or out of range)
- mem_addr  out  32  word index to memory
- mem_wdata  out  32  write data to memory
- mem_we  out  1  memory write enable (memory reads whenever low)
- mem_rdata  in  32  memory read data, registered inside the memory, valid one cycle after address presented with mem_we=0

## Operation
- States: IDLE, ISSUE, WAIT, RESP. Reset state is IDLE.
- IDLE: req_ready=1. Handshake when req_valid&&req_ready at the edge. At that edge, latch write flag, word index = req_addr>>2, and wdata.
  - Error if req_addr[1:0]!=0 or req_addr>>2 >= DEPTH. Error requests go to RESP with resp_err=1 and resp_rdata=0. No memory cycle is issued.
  - Otherwise go to ISSUE.
- ISSUE: mem_addr=latched index, mem_wdata=latched data, mem_we=latched write flag.
  - Store: go to RESP with resp_err=0 and resp_rdata=0.
  - Load: go to WAIT.
- WAIT: mem_we=0, mem_addr held. At the edge ending WAIT, resp_rdata<=mem_rdata, resp_err<=0, then go to RESP.
- RESP: resp_valid=1. resp_rdata and resp_err are held stable until resp_valid&&resp_ready, then go to IDLE.
- mem_we is high only in ISSUE for a store: exactly one cycle per store. It is never high in any other state.
- mem_addr and mem_wdata hold their last latched values outside ISSUE/WAIT. After reset they are 0.
- req_ready=1 only in IDLE. There are no combinational paths from req_* to resp_* or mem_*.
- Widths: mem_addr is the zero-extended index; upper index bits beyond DEPTH are covered by the range check.

## Timing
- Reset values (after any edge with rst_n=0): state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_we=0, mem_addr=0, mem_wdata=0.
- With the request accepted at edge k, resp_valid rises after edge:
  - load: k+3
  - store: k+2, with mem_we high in cycle k+1
  - error: k+1
- Back-to-back: the next request can be accepted one cycle after the response handshake (IDLE lasts at least 1 cycle). Peak throughput is 1 load per 4 cycles and 1 store per 3 cycles.
- Backpressure: while resp_ready=0, stay in RESP indefinitely with outputs frozen and req_ready=0.
- Reset mid-operation: rst_n=0 in any state forces IDLE at that edge and mem_we=0 from the next cycle. The outstanding request is dropped with no response. Memory contents are not affected beyond a store already committed in ISSUE.
- A request held on req_valid during reset is not accepted until the first edge with rst_n=1 in IDLE.

## Test plan
- Store 0xDEADBEEF to 0x0000_0010, then load 0x10. Required:
  - mem_we=1 for one cycle with mem_addr=4
  - store response at k+2 with resp_err=0
  - load response at k+3 with resp_rdata=0xDEADBEEF
- Load 0x0000_0006 (misaligned): resp_valid at k+1, resp_err=1, resp_rdata=0, mem_we never asserted.
- Store to 0x0000_0080 (index 32, DEPTH=32): resp_err=1 and no memory write. Then store/load at 0x7C (index 31) succeeds.
- Load with resp_ready held 0 for 5 cycles: resp_valid and resp_rdata stay stable and req_ready=0 throughout; completion occurs on the cycle resp_ready rises.
- rst_n low during WAIT of a load: no resp_valid, all outputs return to reset values. A subsequent load of the same address returns the correct data.
- Four back-to-back alternating stores/loads at indices 0..3 with resp_ready=1: all data returns correctly, and each response appears at its exact k+2 or k+3 cycle.

Source files
------------

// File: rtl/lsu_mem_ctrl_if.sv
// lsu_mem_ctrl_if
// Bundles the three signal groups around the load/store controller:
//   request  (execute stage -> controller): req_valid, req_ready, req_write,
//            req_addr, req_wdata
//   response (controller -> execute stage): resp_valid, resp_ready,
//            resp_rdata, resp_err
//   memory   (controller <-> data memory):  mem_addr, mem_wdata, mem_we,
//            mem_rdata
// Modport slave is the controller's view; modport master is the view of
// the surrounding logic (requester, response consumer and memory).
interface lsu_mem_ctrl_if #(
    parameter int AW = 32
);
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;

    logic          resp_valid;
    logic          resp_ready;
    logic [31:0]   resp_rdata;
    logic          resp_err;

    logic [31:0]   mem_addr;
    logic [31:0]   mem_wdata;
    logic          mem_we;
    logic [31:0]   mem_rdata;

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        input  resp_ready, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_addr, mem_wdata, mem_we
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        output resp_ready, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl
// Load/store controller in front of a word-addressed, single-port,
// synchronous-read data memory. Accepts one byte-addressed request at a
// time, rejects misaligned or out-of-range addresses without touching the
// memory, runs the memory cycle and returns exactly one response.
// Ports:
//   clk    system clock, rising edge
//   rst_n  synchronous active-low reset
//   bus    lsu_mem_ctrl_if.slave: request handshake, response handshake
//          and memory port (see the interface file)
// Latency from the accepting edge to the first cycle with resp_valid:
//   error 1 cycle, store 2 cycles, load 3 cycles.
module lsu_mem_ctrl #(
    parameter int DEPTH = 32,
    parameter int AW    = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    lsu_mem_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t        state_r;
    logic          wr_r;
    logic          req_ready_r;
    logic          resp_valid_r;
    logic [31:0]   resp_rdata_r;
    logic          resp_err_r;
    logic          mem_we_r;
    logic [31:0]   mem_addr_r;
    logic [31:0]   mem_wdata_r;

    logic [AW-1:0] req_idx_s;
    logic          req_err_s;

    // A request is rejected when it is not word aligned or its word index
    // falls outside the memory.
    function automatic logic addr_err(input logic [AW-1:0] addr);
        logic [AW-1:0] idx;
        idx = addr >> 2;
        return (addr[1:0] != 2'b00) || (idx >= AW'(DEPTH));
    endfunction

    // Decode the word index and error condition of the offered request.
    always_comb begin
        req_idx_s = bus.req_addr >> 2;
        req_err_s = addr_err(bus.req_addr);
    end

    // Request/response sequencer; all outputs are registered here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            wr_r         <= 1'b0;
            req_ready_r  <= 1'b1;
            resp_valid_r <= 1'b0;
            resp_rdata_r <= 32'h0000_0000;
            resp_err_r   <= 1'b0;
            mem_we_r     <= 1'b0;
            mem_addr_r   <= 32'h0000_0000;
            mem_wdata_r  <= 32'h0000_0000;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.req_valid) begin
                        req_ready_r <= 1'b0;
                        wr_r        <= bus.req_write;
                        if (req_err_s) begin
                            // Rejected: answer straight away, memory untouched.
                            resp_valid_r <= 1'b1;
                            resp_err_r   <= 1'b1;
                            resp_rdata_r <= 32'h0000_0000;
                            state_r      <= RESP;
                        end else begin
                            // Index is in range here, so the cast loses nothing.
                            mem_addr_r  <= 32'(req_idx_s);
                            mem_wdata_r <= bus.req_wdata;
                            mem_we_r    <= bus.req_write;
                            state_r     <= ISSUE;
                        end
                    end else begin
                        req_ready_r <= 1'b1;
                    end
                end
                ISSUE: begin
                    // The memory sees exactly one write-enable cycle per store.
                    mem_we_r <= 1'b0;
                    if (wr_r) begin
                        resp_valid_r <= 1'b1;
                        resp_err_r   <= 1'b0;
                        resp_rdata_r <= 32'h0000_0000;
                        state_r      <= RESP;
                    end else begin
                        state_r <= WAIT;
                    end
                end
                WAIT: begin
                    // Registered read data of the address issued last cycle.
                    mem_we_r     <= 1'b0;
                    resp_rdata_r <= bus.mem_rdata;
                    resp_err_r   <= 1'b0;
                    resp_valid_r <= 1'b1;
                    state_r      <= RESP;
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        resp_valid_r <= 1'b0;
                        req_ready_r  <= 1'b1;
                        state_r      <= IDLE;
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    req_ready_r  <= 1'b1;
                    resp_valid_r <= 1'b0;
                    mem_we_r     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready  = req_ready_r;
    assign bus.resp_valid = resp_valid_r;
    assign bus.resp_rdata = resp_rdata_r;
    assign bus.resp_err   = resp_err_r;
    assign bus.mem_we     = mem_we_r;
    assign bus.mem_addr   = mem_addr_r;
    assign bus.mem_wdata  = mem_wdata_r;

endmodule
